// File: rtl/spi_slave_regctl.sv
// Register-bus burst controller behind spi_slave: command byte + data bytes per ssn frame.
// Optional SPI_REGCTL_AUTOINC_EN: advance the register address after every data byte.
module spi_slave_regctl #(
    parameter int unsigned AW        = 7,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter logic [7:0]  STAT_BYTE = 8'h5A
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ssn,
    input  logic [7:0]    data_r_s,
    input  logic          data_finish_s,
    output logic [7:0]    data_s,
    output logic [7:0]    spcon_s,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          ovr,
    output logic          burst_done
);

    typedef enum logic [2:0] {IDLE, CMD, WR, RD_FETCH, RD_WAIT, RD_DATA} state_t;

    state_t        state, state_nxt;
    logic          ssn_meta, ssn_s, ssn_q, fin_q;
    logic          fin, ssn_fall, ssn_rise;
    logic [AW-1:0] addr, addr_nxt, addr_adv;
    logic [7:0]    data_s_nxt, reg_wdata_nxt;
    logic [AW-1:0] reg_addr_nxt;
    logic          reg_we_nxt, reg_re_nxt, busy_nxt, ovr_nxt, burst_done_nxt;

    assign spcon_s = {5'b0, CPOL, CPHA, 1'b0};

`ifdef SPI_REGCTL_AUTOINC_EN
    assign addr_adv = addr + AW'(1);
`else
    assign addr_adv = addr;
`endif

    // ssn synchronizer plus edge history for ssn_s and data_finish_s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssn_meta <= 1'b1;
            ssn_s    <= 1'b1;
            ssn_q    <= 1'b1;
            fin_q    <= 1'b0;
        end else begin
            ssn_meta <= ssn;
            ssn_s    <= ssn_meta;
            ssn_q    <= ssn_s;
            fin_q    <= data_finish_s;
        end
    end

    assign fin      = data_finish_s & ~fin_q;
    assign ssn_fall = ssn_q & ~ssn_s;
    assign ssn_rise = ~ssn_q & ssn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (ssn_fall) state_nxt = CMD;
            CMD:      if (fin) state_nxt = data_r_s[7] ? RD_FETCH : WR;
            WR:       state_nxt = WR;
            RD_FETCH: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = RD_DATA;
            RD_DATA:  if (fin) state_nxt = RD_FETCH;
            default:  state_nxt = IDLE;
        endcase
        if (state != IDLE && ssn_rise) state_nxt = IDLE;
    end

    // Next values of the registered outputs; a fetch is launched on entry to RD_FETCH
    always_comb begin
        addr_nxt       = addr;
        data_s_nxt     = data_s;
        reg_addr_nxt   = reg_addr;
        reg_wdata_nxt  = reg_wdata;
        reg_we_nxt     = 1'b0;
        reg_re_nxt     = 1'b0;
        ovr_nxt        = 1'b0;
        burst_done_nxt = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
        case (state)
            CMD: begin
                if (fin) begin
                    addr_nxt = data_r_s[AW-1:0];
                    if (data_r_s[7] && !ssn_rise) begin
                        reg_re_nxt   = 1'b1;
                        reg_addr_nxt = data_r_s[AW-1:0];
                    end
                end
            end
            WR: begin
                if (fin) begin
                    reg_we_nxt    = 1'b1;
                    reg_wdata_nxt = data_r_s;
                    reg_addr_nxt  = addr;
                    addr_nxt      = addr_adv;
                end
            end
            RD_FETCH: ovr_nxt = fin;
            RD_WAIT: begin
                ovr_nxt    = fin;
                data_s_nxt = reg_rdata;
                addr_nxt   = addr_adv;
            end
            RD_DATA: begin
                if (fin && !ssn_rise) begin
                    reg_re_nxt   = 1'b1;
                    reg_addr_nxt = addr;
                end
            end
            default: ;
        endcase
        if (ssn_rise && state != IDLE && state != CMD) burst_done_nxt = 1'b1;
        if (state_nxt == IDLE) data_s_nxt = STAT_BYTE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            data_s     <= STAT_BYTE;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
            ovr        <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            addr       <= addr_nxt;
            data_s     <= data_s_nxt;
            reg_addr   <= reg_addr_nxt;
            reg_wdata  <= reg_wdata_nxt;
            reg_we     <= reg_we_nxt;
            reg_re     <= reg_re_nxt;
            busy       <= busy_nxt;
            ovr        <= ovr_nxt;
            burst_done <= burst_done_nxt;
        end
    end

endmodule

// File: tb/tb_spi_slave_regctl.sv
// Bench for spi_slave_regctl: transaction-level model schedules expected strobes per cycle.
module tb_spi_slave_regctl;

    localparam int unsigned AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ssn = 1'b1;
    logic [7:0]    data_r_s = 8'h00;
    logic          data_finish_s = 1'b0;
    logic [7:0]    data_s, spcon_s, reg_wdata, reg_rdata;
    logic [AW-1:0] reg_addr;
    logic          reg_we, reg_re, busy, ovr, burst_done;

    spi_slave_regctl #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ssn(ssn),
        .data_r_s(data_r_s), .data_finish_s(data_finish_s),
        .data_s(data_s), .spcon_s(spcon_s),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .busy(busy), .ovr(ovr), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rd_fn(input logic [6:0] a);
        return 8'({1'b0, a} ^ 8'hFF);
    endfunction

    // Register file: data valid exactly one cycle after reg_re, garbage otherwise
    always @(posedge clk) reg_rdata <= reg_re ? rd_fn(reg_addr) : 8'($urandom);

    // Expected events keyed by the cycle in which they must be visible
    logic [14:0] exp_we [int];
    logic [6:0]  exp_re [int];
    logic        exp_ovr [int];
    logic        exp_done [int];
    logic [7:0]  exp_ds [int];
    logic        exp_bz [int];
    logic [7:0]  exp_data_s = 8'h5A;
    logic        exp_busy = 1'b0;
    logic [14:0] act_wr [$];

    logic       m_cmd_seen = 1'b0;
    logic       m_read = 1'b0;
    logic [6:0] m_addr = 7'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_ds.exists(cyc)) exp_data_s = exp_ds[cyc];
            if (exp_bz.exists(cyc)) exp_busy = exp_bz[cyc];
            chk("data_s", 32'(data_s), 32'(exp_data_s));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("spcon_s", 32'(spcon_s), 32'h00);
            chk("reg_we", 32'(reg_we), 32'(exp_we.exists(cyc)));
            if (reg_we && exp_we.exists(cyc))
                chk("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_we[cyc]));
            chk("reg_re", 32'(reg_re), 32'(exp_re.exists(cyc)));
            if (reg_re && exp_re.exists(cyc))
                chk("re_addr", 32'(reg_addr), 32'(exp_re[cyc]));
            chk("ovr", 32'(ovr), 32'(exp_ovr.exists(cyc)));
            chk("burst_done", 32'(burst_done), 32'(exp_done.exists(cyc)));
            chk("we_re_excl", 32'(reg_we & reg_re), 32'h0);
            if (reg_we) act_wr.push_back({reg_addr, reg_wdata});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic advance();
`ifdef SPI_REGCTL_AUTOINC_EN
        m_addr = 7'((int'(m_addr) + 1) % 128);
`endif
    endtask

    // Model reaction to one completed byte seen in cycle c
    task automatic model_fin(input int c, input logic [7:0] d);
        if (!m_cmd_seen) begin
            m_cmd_seen = 1'b1;
            m_read     = d[7];
            m_addr     = d[6:0];
            if (m_read) begin
                exp_re[c+1] = m_addr;
                exp_ds[c+3] = rd_fn(m_addr);
                advance();
            end
        end else if (m_read) begin
            exp_re[c+1] = m_addr;
            exp_ds[c+3] = rd_fn(m_addr);
            advance();
        end else begin
            exp_we[c+1] = {m_addr, d};
            advance();
        end
    endtask

    task automatic start_frame();
        ssn = 1'b0;
        exp_bz[cyc+3] = 1'b1;
        m_cmd_seen = 1'b0;
        tick(5);
    endtask

    task automatic end_marks(input int c);
        exp_bz[c+3] = 1'b0;
        exp_ds[c+3] = 8'h5A;
        if (m_cmd_seen) exp_done[c+3] = 1'b1;
    endtask

    task automatic end_frame();
        ssn = 1'b1;
        end_marks(cyc);
        tick(6);
    endtask

    task automatic send_byte(input logic [7:0] d, input int w, input int gap);
        data_r_s = d;
        data_finish_s = 1'b1;
        model_fin(cyc, d);
        tick(w);
        data_finish_s = 1'b0;
        tick(gap - w);
    endtask

    // Last byte completes in the very cycle the synchronized ssn rises
    task automatic end_frame_with_byte(input logic [7:0] d);
        int c;
        ssn = 1'b1;
        c = cyc;
        tick(2);
        data_r_s = d;
        data_finish_s = 1'b1;
        model_fin(cyc, d);
        end_marks(c);
        tick(1);
        data_finish_s = 1'b0;
        tick(6);
    endtask

    initial begin
        int c;
        tick(1);
        chk("rst_data_s", 32'(data_s), 32'h5A);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", 32'({reg_we, reg_re, ovr, burst_done}), 32'h0);
        chk("rst_addr", 32'(reg_addr), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Command byte only: status byte out, no strobes
        act_wr.delete();
        start_frame();
        chk("cmd_busy", 32'(busy), 32'h1);
        chk("cmd_data_s", 32'(data_s), 32'h5A);
        send_byte(8'h00, 1, 9);
        chk("cmd_no_wr", 32'(act_wr.size()), 32'h0);
        end_frame();

        // Frame without any byte: no burst_done
        start_frame();
        end_frame();

        // Write burst
        act_wr.delete();
        start_frame();
        send_byte(8'h10, 1, 9);
        send_byte(8'hAA, 2, 9);
        send_byte(8'hBB, 3, 10);
        end_frame();
        chk("wr_count", 32'(act_wr.size()), 32'h2);
        chk("wr_first", 32'(act_wr[0]), 32'h10AA);
`ifdef SPI_REGCTL_AUTOINC_EN
        chk("wr_second", 32'(act_wr[1]), 32'h11BB);
`else
        chk("wr_second", 32'(act_wr[1]), 32'h10BB);
`endif

        // Read burst from 0x05
        start_frame();
        send_byte(8'h85, 1, 9);
        chk("rd_byte0", 32'(data_s), 32'hFA);
        send_byte(8'h33, 2, 9);
`ifdef SPI_REGCTL_AUTOINC_EN
        chk("rd_byte1", 32'(data_s), 32'hF9);
`else
        chk("rd_byte1", 32'(data_s), 32'hFA);
`endif
        send_byte(8'h44, 1, 9);
        end_frame();

        // Address wrap
        act_wr.delete();
        start_frame();
        send_byte(8'h7F, 1, 9);
        send_byte(8'h11, 1, 9);
        send_byte(8'h22, 1, 9);
        end_frame();
        chk("wrap_first", 32'(act_wr[0]), 32'h7F11);
`ifdef SPI_REGCTL_AUTOINC_EN
        chk("wrap_second", 32'(act_wr[1]), 32'h0022);
`else
        chk("wrap_second", 32'(act_wr[1]), 32'h7F22);
`endif

        // Overrun: second finish pulse one cycle after reg_re
        start_frame();
        c = cyc;
        data_r_s = 8'hA0;
        data_finish_s = 1'b1;
        model_fin(c, 8'hA0);
        tick(1);
        data_finish_s = 1'b0;
        tick(1);
        data_finish_s = 1'b1;
        exp_ovr[c+3] = 1'b1;
        tick(1);
        data_finish_s = 1'b0;
        tick(8);
        chk("ovr_prefetch", 32'(data_s), 32'hDF);
        send_byte(8'h00, 1, 9);
        end_frame();

        // Abort during a write data byte
        act_wr.delete();
        start_frame();
        send_byte(8'h03, 1, 9);
        end_frame();
        chk("abort_no_wr", 32'(act_wr.size()), 32'h0);

        // Last byte and ssn rise coincide
        act_wr.delete();
        start_frame();
        send_byte(8'h40, 1, 9);
        end_frame_with_byte(8'h5C);
        chk("same_cycle_wr", 32'(act_wr[0]), 32'h405C);

        // Reset in the middle of a read fetch
        start_frame();
        data_r_s = 8'h85;
        data_finish_s = 1'b1;
        model_fin(cyc, 8'h85);
        tick(1);
        rst_n = 1'b0;
        data_finish_s = 1'b0;
        ssn = 1'b1;
        exp_we.delete(); exp_re.delete(); exp_ovr.delete();
        exp_done.delete(); exp_ds.delete(); exp_bz.delete();
        exp_ds[cyc] = 8'h5A;
        exp_bz[cyc] = 1'b0;
        #1;
        chk("mid_rst_re", 32'(reg_re), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_data_s", 32'(data_s), 32'h5A);
        tick(3);
        rst_n = 1'b1;
        tick(4);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int nb;
            start_frame();
            if ($urandom_range(0, 7) != 0) begin
                send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(8, 12));
                nb = $urandom_range(0, 4);
                for (int b = 0; b < nb; b++)
                    send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(8, 12));
            end
            end_frame();
        end

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regctl.md
# spi_slave_regctl

Transaction controller sitting behind `spi_slave`. It turns the byte stream delivered by the slave into register-bus read/write bursts, and supplies the slave's transmit byte (`data_s`) and its static configuration (`spcon_s`). Every SPI frame (ssn low) is one burst: a command byte followed by any number of data bytes, with address auto-increment.

## Interface
- `AW`, default 7: register address width, 1..7; command byte bits [AW-1:0] give the start address.
- `CPOL`, default 0: drives `spcon_s[2]`.
- `CPHA`, default 0: drives `spcon_s[1]`.
- `STAT_BYTE`, default 8'h5A: byte returned to the master during the command byte.
- `clk` in 1: system clock, same as `spi_slave`.
- `rst_n` in 1: asynchronous, active-low reset.
- `ssn` in 1: raw slave select, same pin as the slave; synchronized internally with 2 FFs (`ssn_s`).
- `data_r_s` in 8: received byte from the slave.
- `data_finish_s` in 1: byte-complete pulse from the slave.
- `data_s` out 8: transmit byte to the slave.
- `spcon_s` out 8: `{5'b0, CPOL, CPHA, 1'b0}`, constant.
- `reg_addr` out AW: register address.
- `reg_wdata` out 8: write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid exactly 1 cycle after `reg_re`.
- `busy` out 1: high while a burst is in progress (state ≠ IDLE).
- `ovr` out 1: one-cycle pulse on read overrun.
- `burst_done` out 1: one-cycle pulse at the end of a frame that contained a command byte.

## Operation
- Reset values:
  - `data_s` = STAT_BYTE.
  - `reg_addr`, `reg_wdata`, `reg_we`, `reg_re`, `busy`, `ovr`, `burst_done` = 0.
  - `ssn_s` sync FFs = 1.
  - state = IDLE.
- Byte-complete event `fin` = rising edge of `data_finish_s` (registered previous value). Each slave pulse counts once, regardless of its width.
- Command byte: bit7 = 1 means read, 0 means write. Bits [AW-1:0] = start address; bits [6:AW] are ignored.
- States:
  - **IDLE**: `data_s` = STAT_BYTE. `ssn_s` falling → CMD.
  - **CMD**: on `fin`, latch the address. Write command → WR. Read command → RD_FETCH.
  - **WR**: on `fin`, drive `reg_we` = 1, `reg_wdata` = `data_r_s`, `reg_addr` = addr, then advance addr. Stay in WR.
  - **RD_FETCH**: drive `reg_re` = 1 with `reg_addr` = addr for one cycle → RD_WAIT.
  - **RD_WAIT**: `data_s` ← `reg_rdata`, advance addr → RD_DATA.
  - **RD_DATA**: on `fin` (byte sent) → RD_FETCH to prefetch the next byte. Bytes written by the master during a read burst are discarded.
- `fin` while in RD_FETCH or RD_WAIT: `ovr` pulses, the event is otherwise ignored, and the prefetch completes normally.
- From any non-IDLE state, `ssn_s` rising → IDLE:
  - `burst_done` pulses if the state was not CMD.
  - A partial byte is discarded; the slave never reports it.
- Address advance: addr + 1 mod 2^AW, so 2^AW−1 wraps to 0. Affected by `SPI_REGCTL_AUTOINC_EN` (see Configuration).

## Timing
- `fin` detected in cycle T:
  - WR: `reg_we` is high in cycle T+1.
  - Read: `reg_re` is high in T+1 and `data_s` is updated at the end of T+2.
- Master constraint: the first SCK edge of the next byte must come no earlier than 6 clk cycles after `data_finish_s` rises. This covers 1 cycle of finish edge detection, 3 cycles of fetch, and slave sampling margin.
- `ssn` to `ssn_s` latency: 2 cycles. The master must hold ssn high for at least 4 clk cycles between frames.
- `fin` and `ssn_s` rising in the same cycle: the byte is processed first (a write is still issued in T+1), then the block enters IDLE and `burst_done` pulses in T+1.
- `reg_we` and `reg_re` are never high in the same cycle.
- `rst_n` asserted mid-burst: all outputs return to reset values immediately, with no partial bus cycle.

## Configuration
- `SPI_REGCTL_AUTOINC_EN` defined: the address advances after every data byte, with wrap as above.
- Not defined: the address is held, so every data byte in the burst reads or writes the command address (FIFO-port style).

## Test plan
- Reset, then ssn low and one byte 8'h00 → `data_s` = 8'h5A during the command byte, `busy` = 1, no bus strobes.
- Write burst: cmd 8'h10, data 8'hAA, 8'hBB, ssn high → `reg_we` with (0x10, AA) then (0x11, BB), each 1 cycle after `fin`; one `burst_done` pulse.
- Read burst: cmd 8'h85, with the bench register model returning addr^8'hFF → the master shifts in 8'hFA, then 8'hF9; `reg_re` asserted for 0x05, then 0x06; `data_s` updated 2 cycles after each `reg_re`.
- Wrap: with AW = 7, write cmd 8'h7F plus 2 data bytes → writes at 0x7F, then 0x00. Without the macro, both writes go to 0x7F.
- Overrun: a second `data_finish_s` pulse 1 cycle after `reg_re` → `ovr` pulses once, and the prefetch still loads `data_s`.
- Abort and reset: ssn high after 3 bits of a write data byte → no `reg_we`, IDLE, `burst_done` = 1. `rst_n` low mid-read → all outputs at reset values, state IDLE.
